// File: rtl/plab3_mem_tdm_mem_arbiter.sv
// Time-division-multiplexed memory arbiter for two security-domain L2 caches.
// Slot ownership depends only on cycle count. A single response buffer is drained only in its owner's slot.
module plab3_mem_tdm_mem_arbiter #(
  parameter  int unsigned p_opaque_nbits = 8,
  parameter  int unsigned p_slot_len     = 16,
  parameter  int unsigned p_guard        = 4,
  parameter  int unsigned clw            = 128,
  parameter  int unsigned abw            = 32,
  localparam int unsigned req_nbits      = 3 + p_opaque_nbits + abw + 4 + clw,
  localparam int unsigned resp_nbits     = 3 + p_opaque_nbits + 4 + clw
) (
  input  logic                  clk,
  input  logic                  reset,

  input  logic                  req0_val,
  output logic                  req0_rdy,
  input  logic [req_nbits-1:0]  req0_msg,
  output logic                  resp0_val,
  input  logic                  resp0_rdy,
  output logic [resp_nbits-1:0] resp0_msg,

  input  logic                  req1_val,
  output logic                  req1_rdy,
  input  logic [req_nbits-1:0]  req1_msg,
  output logic                  resp1_val,
  input  logic                  resp1_rdy,
  output logic [resp_nbits-1:0] resp1_msg,

  output logic                  memreq_val,
  input  logic                  memreq_rdy,
  output logic [req_nbits-1:0]  memreq_msg,
  input  logic                  memresp_val,
  output logic                  memresp_rdy,
  input  logic [resp_nbits-1:0] memresp_msg,

  output logic                  cur_domain
);

  localparam int unsigned cnt_nbits = (p_slot_len > 2) ? $clog2(p_slot_len) : 1;
  localparam logic [cnt_nbits-1:0] slot_last = cnt_nbits'(p_slot_len - 1);
  localparam logic [cnt_nbits-1:0] win_end   = cnt_nbits'(p_slot_len - p_guard);

  typedef enum logic {
    DOM_L = 1'b0,
    DOM_H = 1'b1
  } dom_e;

  logic [cnt_nbits-1:0]  slot_cnt_q, slot_cnt_d;
  dom_e                  cur_domain_q, cur_domain_d;
  dom_e                  owner_q, owner_d;
  logic                  outst_q, outst_d;
  logic                  buf_full_q, buf_full_d;
  logic [resp_nbits-1:0] buf_q, buf_d;

  logic win;
  logic can_issue;
  logic req_fire;
  logic memresp_fire;
  logic deliver;
  logic deliver_fire;

  always_comb begin
    win          = (slot_cnt_q < win_end);
    can_issue    = win & ~outst_q & ~buf_full_q & ~reset;

    memreq_val   = ((cur_domain_q == DOM_H) ? req1_val : req0_val) & can_issue;
    memreq_msg   = (cur_domain_q == DOM_H) ? req1_msg : req0_msg;
    req0_rdy     = memreq_rdy & can_issue & (cur_domain_q == DOM_L);
    req1_rdy     = memreq_rdy & can_issue & (cur_domain_q == DOM_H);
    req_fire     = memreq_val & memreq_rdy;

    memresp_rdy  = ~buf_full_q & ~reset;
    memresp_fire = memresp_val & memresp_rdy;

    // Messages are zeroed while invalid so stale buffer contents of one domain never reach the other.
    deliver      = buf_full_q & (owner_q == cur_domain_q) & ~reset;
    resp0_val    = deliver & (owner_q == DOM_L);
    resp1_val    = deliver & (owner_q == DOM_H);
    resp0_msg    = resp0_val ? buf_q : '0;
    resp1_msg    = resp1_val ? buf_q : '0;
    deliver_fire = (resp0_val & resp0_rdy) | (resp1_val & resp1_rdy);

    cur_domain   = cur_domain_q;

    slot_cnt_d   = (slot_cnt_q == slot_last) ? '0 : slot_cnt_q + 1'b1;
    cur_domain_d = cur_domain_q;
    if (slot_cnt_q == slot_last)
      cur_domain_d = (cur_domain_q == DOM_L) ? DOM_H : DOM_L;

    outst_d    = outst_q;
    owner_d    = owner_q;
    buf_full_d = buf_full_q;
    buf_d      = buf_q;
    if (deliver_fire) begin
      buf_full_d = 1'b0;
      outst_d    = 1'b0;
    end
    if (req_fire) begin
      outst_d = 1'b1;
      owner_d = cur_domain_q;
    end
    if (memresp_fire) begin
      buf_full_d = 1'b1;
      buf_d      = memresp_msg;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      slot_cnt_q   <= '0;
      cur_domain_q <= DOM_L;
      owner_q      <= DOM_L;
      outst_q      <= 1'b0;
      buf_full_q   <= 1'b0;
      buf_q        <= '0;
    end else begin
      slot_cnt_q   <= slot_cnt_d;
      cur_domain_q <= cur_domain_d;
      owner_q      <= owner_d;
      outst_q      <= outst_d;
      buf_full_q   <= buf_full_d;
      buf_q        <= buf_d;
    end
  end

endmodule

// File: tb/tb_plab3_mem_tdm_mem_arbiter.sv
// Directed self-checking bench for the TDM memory arbiter (slot length 8, guard 2).
module tb_plab3_mem_tdm_mem_arbiter;

  localparam int unsigned REQ_W  = 175;
  localparam int unsigned RESP_W = 143;

  logic              clk, reset;
  logic              req0_val, req0_rdy, resp0_val, resp0_rdy;
  logic              req1_val, req1_rdy, resp1_val, resp1_rdy;
  logic [REQ_W-1:0]  req0_msg, req1_msg, memreq_msg;
  logic [RESP_W-1:0] resp0_msg, resp1_msg, memresp_msg;
  logic              memreq_val, memreq_rdy, memresp_val, memresp_rdy;
  logic              cur_domain;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  plab3_mem_tdm_mem_arbiter #(
    .p_opaque_nbits (8),
    .p_slot_len     (8),
    .p_guard        (2),
    .clw            (128),
    .abw            (32)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req0_val    (req0_val),
    .req0_rdy    (req0_rdy),
    .req0_msg    (req0_msg),
    .resp0_val   (resp0_val),
    .resp0_rdy   (resp0_rdy),
    .resp0_msg   (resp0_msg),
    .req1_val    (req1_val),
    .req1_rdy    (req1_rdy),
    .req1_msg    (req1_msg),
    .resp1_val   (resp1_val),
    .resp1_rdy   (resp1_rdy),
    .resp1_msg   (resp1_msg),
    .memreq_val  (memreq_val),
    .memreq_rdy  (memreq_rdy),
    .memreq_msg  (memreq_msg),
    .memresp_val (memresp_val),
    .memresp_rdy (memresp_rdy),
    .memresp_msg (memresp_msg),
    .cur_domain  (cur_domain)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [199:0] got, input logic [199:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [REQ_W-1:0] mk_req(input logic [7:0] opq, input logic [31:0] addr);
    return {3'd0, opq, addr, 4'd0, 128'd0};
  endfunction

  function automatic logic [RESP_W-1:0] mk_resp(input logic [7:0] opq, input logic [127:0] data);
    return {3'd0, opq, 4'd0, data};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    req0_val = 0; req1_val = 0; memresp_val = 0;
    req0_msg = '0; req1_msg = '0; memresp_msg = '0;
    memreq_rdy = 1; resp0_rdy = 1; resp1_rdy = 1;
    reset = 1;
    @(posedge clk);
    #1;
    reset = 0;
    cyc = 0;
  endtask

  logic [REQ_W-1:0]  m_req, m_req1;
  logic [RESP_W-1:0] m_resp;
  logic [144:0]      tr [2][48];
  logic              pend;
  int                due;
  logic [RESP_W-1:0] mmsg;
  int                n_del;

  initial begin
    reset = 1; req0_val = 0; req1_val = 0; memresp_val = 0;
    req0_msg = '0; req1_msg = '0; memresp_msg = '0;
    memreq_rdy = 1; resp0_rdy = 1; resp1_rdy = 1;
    @(posedge clk);

    // Idle slot timing
    do_reset();
    for (int c = 0; c <= 16; c++) begin
      #1;
      chk($sformatf("p1 dom c%0d", c), cur_domain, (c / 8) % 2);
      chk($sformatf("p1 vals c%0d", c), {memreq_val, resp0_val, resp1_val}, 3'b000);
      step();
    end

    // Single domain-0 read
    do_reset();
    m_req  = mk_req(8'h5A, 32'h0000_1000);
    m_resp = mk_resp(8'h5A, 128'hCAFE_0000_1000);
    step();
    req0_val = 1; req0_msg = m_req;
    #1;
    chk("p2 c1 memreq_val", memreq_val, 1'b1);
    chk("p2 c1 memreq_msg", memreq_msg, m_req);
    chk("p2 c1 req0_rdy", req0_rdy, 1'b1);
    step();
    req0_msg = mk_req(8'h77, 32'h0000_2000);
    memresp_val = 1; memresp_msg = m_resp;
    #1;
    chk("p2 c2 req0_rdy", req0_rdy, 1'b0);
    chk("p2 c2 memreq_val", memreq_val, 1'b0);
    chk("p2 c2 memresp_rdy", memresp_rdy, 1'b1);
    chk("p2 c2 resp0_val", resp0_val, 1'b0);
    step();
    req0_val = 0; memresp_val = 0;
    #1;
    chk("p2 c3 resp0_val", resp0_val, 1'b1);
    chk("p2 c3 resp0_msg", resp0_msg, m_resp);
    chk("p2 c3 resp1_val", resp1_val, 1'b0);
    chk("p2 c3 req0_rdy", req0_rdy, 1'b0);
    chk("p2 c3 memresp_rdy", memresp_rdy, 1'b0);
    step();
    #1;
    chk("p2 c4 resp0_val", resp0_val, 1'b0);
    chk("p2 c4 req0_rdy", req0_rdy, 1'b1);

    // Memory never ready in slot 0, then guard-band request for domain 1
    do_reset();
    memreq_rdy = 0; req0_val = 1; req0_msg = m_req;
    m_req1 = mk_req(8'hB1, 32'h0000_3000);
    req1_msg = m_req1;
    for (int c = 0; c <= 25; c++) begin
      if (c == 8) begin memreq_rdy = 1; req0_val = 0; end
      if (c == 14) req1_val = 1;
      if (c == 25) req1_val = 0;
      #1;
      if (c < 6) begin
        chk($sformatf("p3 req0_rdy c%0d", c), req0_rdy, 1'b0);
        chk($sformatf("p3 memreq_val c%0d", c), memreq_val, 1'b1);
      end
      if (c == 6) chk("p3 guard memreq_val c6", memreq_val, 1'b0);
      if (c >= 14 && c < 24) begin
        chk($sformatf("p3 req1_rdy c%0d", c), req1_rdy, 1'b0);
        chk($sformatf("p3 memreq_val c%0d", c), memreq_val, 1'b0);
      end
      if (c == 24) begin
        chk("p3 c24 req1_rdy", req1_rdy, 1'b1);
        chk("p3 c24 memreq_val", memreq_val, 1'b1);
        chk("p3 c24 memreq_msg", memreq_msg, m_req1);
        chk("p3 c24 cur_domain", cur_domain, 1'b1);
      end
      if (c == 25) chk("p3 c25 req1_rdy", req1_rdy, 1'b0);
      step();
    end

    // Late response held until the owner's next slot
    do_reset();
    m_resp = mk_resp(8'h44, 128'h1234_5678);
    req0_msg = mk_req(8'h44, 32'h0000_4000);
    memresp_msg = m_resp;
    for (int c = 0; c <= 17; c++) begin
      req0_val = (c == 5);
      memresp_val = (c == 11);
      #1;
      if (c == 5) chk("p4 c5 memreq_val", memreq_val, 1'b1);
      if (c == 11) chk("p4 c11 memresp_rdy", memresp_rdy, 1'b1);
      if (c >= 12 && c <= 16) chk($sformatf("p4 memresp_rdy c%0d", c), memresp_rdy, 1'b0);
      if (c >= 6 && c <= 15) chk($sformatf("p4 resp vals c%0d", c), {resp0_val, resp1_val}, 2'b00);
      if (c == 16) begin
        chk("p4 c16 resp0_val", resp0_val, 1'b1);
        chk("p4 c16 resp0_msg", resp0_msg, m_resp);
      end
      if (c == 17) begin
        chk("p4 c17 resp0_val", resp0_val, 1'b0);
        chk("p4 c17 memresp_rdy", memresp_rdy, 1'b1);
      end
      step();
    end

    // Non-interference: same domain-0 trace, domain 1 idle vs saturating
    n_del = 0;
    for (int run = 0; run < 2; run++) begin
      do_reset();
      pend = 0; due = 0; mmsg = '0;
      req1_msg = mk_req(8'hEE, 32'hDEAD_0000);
      for (int c = 0; c < 48; c++) begin
        req0_val = ((c % 6) != 3);
        req0_msg = mk_req(8'(c), 32'h2000 + 32'(c * 4));
        req1_val = (run == 1);
        memresp_val = pend && (due == c);
        memresp_msg = mmsg;
        #1;
        tr[run][c] = {req0_rdy, resp0_val, resp0_msg};
        if (run == 0 && resp0_val) n_del++;
        if (memresp_val && memresp_rdy) pend = 0;
        if (memreq_val && memreq_rdy) begin
          pend = 1;
          due  = c + 1;
          mmsg = mk_resp(memreq_msg[171:164], {96'd0, memreq_msg[163:132]});
        end
        step();
      end
    end
    chk("p5 domain-0 deliveries seen", (n_del >= 4), 1'b1);
    for (int c = 0; c < 48; c++)
      chk($sformatf("p5 d0 trace c%0d", c), tr[1][c], tr[0][c]);

    // Reset in the middle of a transaction
    do_reset();
    resp0_rdy = 0;
    m_req  = mk_req(8'h66, 32'h0000_6000);
    m_resp = mk_resp(8'h66, 128'hABCD);
    step();
    req0_val = 1; req0_msg = m_req;
    #1;
    chk("p6 c1 memreq_val", memreq_val, 1'b1);
    step();
    req0_val = 0; memresp_val = 1; memresp_msg = m_resp;
    step();
    memresp_val = 0;
    #1;
    chk("p6 c3 resp0_val held", resp0_val, 1'b1);
    reset = 1; req0_val = 1;
    #1;
    chk("p6 reset-cycle outputs",
        {memreq_val, req0_rdy, req1_rdy, resp0_val, resp1_val, memresp_rdy, cur_domain}, 7'd0);
    @(posedge clk);
    #1;
    reset = 0; cyc = 0; resp0_rdy = 1;
    #1;
    chk("p6 post vals", {resp0_val, resp1_val}, 2'b00);
    chk("p6 post memresp_rdy", memresp_rdy, 1'b1);
    chk("p6 post req0_rdy", req0_rdy, 1'b1);
    chk("p6 post memreq_val", memreq_val, 1'b1);
    chk("p6 post memreq_msg", memreq_msg, m_req);
    for (int c = 1; c <= 8; c++) begin
      step();
      req0_val = 0;
      #1;
      if (c == 7) chk("p6 c7 cur_domain", cur_domain, 1'b0);
      if (c == 8) chk("p6 c8 cur_domain", cur_domain, 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
